lz77_job_arbiter: RTL and testbench

//  Shares one LZ77 encoder core between N requesters, one job at a time.

---
 rtl/lz77_job_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_lz77_job_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_job_arbiter.sv
// Round-robin arbiter sharing one LZ77 encoder core between N requesters, one job at a time.
// Each job resets the core, streams LOAD_LEN bytes in, forwards tokens back, then reports done or timeout.
module lz77_job_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOAD_LEN = 2049,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   grant,
  output logic           data_rd,
  output logic           core_reset,
  output logic [7:0]     core_data,
  input  logic           core_valid,
  input  logic           core_finish,
  input  logic [3:0]     core_offset,
  input  logic [2:0]     core_len,
  input  logic [7:0]     core_char,
  output logic           tok_valid,
  output logic [3:0]     tok_offset,
  output logic [2:0]     tok_len,
  output logic [7:0]     tok_char,
  output logic [N-1:0]   done,
  output logic [N-1:0]   err
);

  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned LCW = 12;
  localparam int unsigned RCW = 13;

  typedef enum logic [2:0] {IDLE, CRST, LOAD, RUN, DONE, ABORT} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [LCW-1:0] load_cnt_q, load_cnt_d;
  logic [RCW-1:0] run_cnt_q, run_cnt_d;
  logic           tok_valid_q, tok_valid_d;
  logic [3:0]     tok_offset_q, tok_offset_d;
  logic [2:0]     tok_len_q, tok_len_d;
  logic [7:0]     tok_char_q, tok_char_d;
  logic [N-1:0]   done_q, done_d;
  logic [N-1:0]   err_q, err_d;

  logic [7:0]     req_bytes [N];
  logic           pick_found;
  logic [PW-1:0]  pick_idx;
  logic [SW-1:0]  scan_idx;
  logic [PW-1:0]  next_ptr;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo N
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + SW'(i);
      if (scan_idx >= SW'(N)) begin
        scan_idx = scan_idx - SW'(N);
      end
      if (!pick_found && req[scan_idx[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[PW-1:0];
      end
    end
  end

  assign next_ptr = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    load_cnt_d   = load_cnt_q;
    run_cnt_d    = run_cnt_q;
    tok_valid_d  = 1'b0;
    tok_offset_d = tok_offset_q;
    tok_len_d    = tok_len_q;
    tok_char_d   = tok_char_q;
    done_d       = '0;
    err_d        = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = N'(1) << pick_idx;
          state_d = CRST;
        end
      end
      CRST: begin
        load_cnt_d = '0;
        run_cnt_d  = '0;
        state_d    = LOAD;
      end
      LOAD: begin
        load_cnt_d = load_cnt_q + 1'b1;
        if (load_cnt_q == LCW'(LOAD_LEN - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (core_valid) begin
          tok_valid_d  = 1'b1;
          tok_offset_d = core_offset;
          tok_len_d    = core_len;
          tok_char_d   = core_char;
          run_cnt_d    = '0;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
        // A finish on the timeout cycle still completes the job normally
        if (core_finish) begin
          done_d  = grant_q;
          state_d = DONE;
        end else if (run_cnt_q == RCW'(TIMEOUT - 1)) begin
          err_d   = grant_q;
          state_d = ABORT;
        end
      end
      DONE, ABORT: begin
        rr_ptr_d = next_ptr;
        grant_d  = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      load_cnt_q   <= '0;
      run_cnt_q    <= '0;
      tok_valid_q  <= 1'b0;
      tok_offset_q <= '0;
      tok_len_q    <= '0;
      tok_char_q   <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      load_cnt_q   <= load_cnt_d;
      run_cnt_q    <= run_cnt_d;
      tok_valid_q  <= tok_valid_d;
      tok_offset_q <= tok_offset_d;
      tok_len_q    <= tok_len_d;
      tok_char_q   <= tok_char_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Core-side strobes decode the current state so reset takes effect without a clock
  assign data_rd    = (state_q == LOAD);
  assign core_data  = (state_q == LOAD) ? req_bytes[owner_q] : 8'h00;
  assign core_reset = reset | (state_q == CRST) | (state_q == ABORT);

  assign grant      = grant_q;
  assign tok_valid  = tok_valid_q;
  assign tok_offset = tok_offset_q;
  assign tok_len    = tok_len_q;
  assign tok_char   = tok_char_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lz77_job_arbiter.sv
// Scoreboard bench for lz77_job_arbiter: directed jobs push expected events, a monitor pops and compares.
module tb_lz77_job_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned LOAD_LEN = 2049;
  localparam int unsigned TIMEOUT  = 16;

  localparam int K_GRANT = 0;
  localparam int K_TOK   = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic           data_rd;
  logic           core_reset;
  logic [7:0]     core_data;
  logic           core_valid;
  logic           core_finish;
  logic [3:0]     core_offset;
  logic [2:0]     core_len;
  logic [7:0]     core_char;
  logic           tok_valid;
  logic [3:0]     tok_offset;
  logic [2:0]     tok_len;
  logic [7:0]     tok_char;
  logic [N-1:0]   done;
  logic [N-1:0]   err;

  lz77_job_arbiter #(.N(N), .LOAD_LEN(LOAD_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
    .data_rd(data_rd), .core_reset(core_reset), .core_data(core_data),
    .core_valid(core_valid), .core_finish(core_finish), .core_offset(core_offset),
    .core_len(core_len), .core_char(core_char), .tok_valid(tok_valid),
    .tok_offset(tok_offset), .tok_len(tok_len), .tok_char(tok_char),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [14:0] val;
    int          aux;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [14:0] tok_tab [3] = '{15'h1941, 15'h4d6c, 15'h7f7a};
  int          ntok = 0;
  int          mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic logic [7:0] exp_byte(logic [3:0] g);
    case (g)
      4'b0001: return 8'h11;
      4'b0010: return 8'h22;
      4'b0100: return 8'h33;
      4'b1000: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push(input int kind, input logic [14:0] val, input int aux);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.aux  = aux;
    exp_q.push_back(e);
  endtask

  task automatic push_job(input logic [3:0] g, input int nt, input int done_tv);
    push(K_GRANT, 15'(g), 0);
    for (int t = 0; t < nt; t++) push(K_TOK, tok_tab[t], 0);
    push(K_DONE, 15'(g), done_tv);
  endtask

  task automatic get_exp(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1;
    e.val  = '0;
    e.aux  = 0;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: got unexpected kind %0d, expected nothing pending (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        miscompares++;
        $display("FAIL event order: got kind %0d expected kind %0d (cycle %0d)", kind, e.kind, cyc);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Encoder core model: counts loaded bytes, then emits ntok tokens on back-to-back cycles
  initial begin : core_model
    int m_rd;
    int m_i;
    m_rd = 0;
    m_i  = 0;
    core_valid = 1'b0; core_finish = 1'b0;
    core_offset = '0; core_len = '0; core_char = '0;
    forever begin
      @(negedge clk);
      core_valid  = 1'b0;
      core_finish = 1'b0;
      if (core_reset) begin
        m_rd = 0;
        m_i  = 0;
      end else if (data_rd) begin
        m_rd++;
      end else if (m_rd == int'(LOAD_LEN)) begin
        if (m_i < ntok) begin
          core_valid = 1'b1;
          {core_offset, core_len, core_char} = tok_tab[m_i];
          if (mode == 1 && m_i == ntok - 1) begin
            core_finish = 1'b1;
            m_rd = 0;
            m_i  = 0;
          end else begin
            m_i++;
          end
        end else if (mode != 2) begin
          core_finish = 1'b1;
          m_rd = 0;
          m_i  = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t       e;
    bit         ok;
    logic [3:0] prev_grant;
    logic [3:0] cur_grant;
    logic       prev_rd;
    int         rd_cnt;
    int         bad_bytes;
    int         run_entry;
    prev_grant = '0; cur_grant = '0; prev_rd = 1'b0;
    rd_cnt = 0; bad_bytes = 0; run_entry = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_grant = grant;
        prev_rd    = 1'b0;
      end else begin
        if (prev_grant == 4'b0 && grant != 4'b0) begin
          get_exp(K_GRANT, e, ok);
          if (ok) check("grant", 32'(grant), 32'(e.val));
          cur_grant = e.val[3:0];
          rd_cnt    = 0;
          bad_bytes = 0;
        end
        if (data_rd) begin
          rd_cnt++;
          if (core_data !== exp_byte(cur_grant)) bad_bytes++;
        end
        if (prev_rd && !data_rd) run_entry = cyc;
        if (tok_valid) begin
          get_exp(K_TOK, e, ok);
          if (ok) check("token", 32'({tok_offset, tok_len, tok_char}), 32'(e.val));
          if (ok) check("tok_grant_nonzero", 32'(grant != 4'b0), 32'd1);
        end
        if (done != 4'b0) begin
          get_exp(K_DONE, e, ok);
          if (ok) begin
            check("done", 32'(done), 32'(e.val));
            check("grant_at_done", 32'(grant), 32'(e.val));
            check("load_cycles", 32'(rd_cnt), 32'(LOAD_LEN));
            check("core_data_errors", 32'(bad_bytes), 32'd0);
            check("tok_valid_at_done", 32'(tok_valid), 32'(e.aux));
          end
        end
        if (err != 4'b0) begin
          get_exp(K_ERR, e, ok);
          if (ok) begin
            check("err", 32'(err), 32'(e.val));
            check("grant_at_err", 32'(grant), 32'(e.val));
            check("abort_delay", 32'(cyc - run_entry), 32'(e.aux));
            check("core_reset_abort", 32'(core_reset), 32'd1);
            check("load_cycles_err", 32'(rd_cnt), 32'(LOAD_LEN));
          end
        end
        prev_grant = grant;
        prev_rd    = data_rd;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    int n;
    reset    = 1'b1;
    req      = '0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_data_rd", 32'(data_rd), 32'd0);
    check("rst_tok_valid", 32'(tok_valid), 32'd0);
    check("rst_tok_fields", 32'({tok_offset, tok_len, tok_char}), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_core_data", 32'(core_data), 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    check("idle_core_reset", 32'(core_reset), 32'd0);

    // Single requester, three tokens then finish
    ntok = 3; mode = 0;
    push_job(4'b0001, 3, 0);
    req = 4'b0001;
    drain(3000);
    req = '0;

    // All requesters held: full round-robin rotation
    pulse_reset();
    ntok = 1; mode = 0;
    push_job(4'b0001, 1, 0);
    push_job(4'b0010, 1, 0);
    push_job(4'b0100, 1, 0);
    push_job(4'b1000, 1, 0);
    push_job(4'b0001, 1, 0);
    req = 4'b1111;
    drain(15000);
    req = '0;

    // Job on 1 leaves rr_ptr at 2, so 1010 serves 3 before 1
    ntok = 0; mode = 0;
    push_job(4'b0010, 0, 0);
    req = 4'b0010;
    drain(3000);
    req = '0;
    ntok = 1;
    push_job(4'b1000, 1, 0);
    push_job(4'b0010, 1, 0);
    req = 4'b1010;
    drain(6000);
    req = '0;

    // Core never finishes: abort after TIMEOUT RUN cycles, then a normal job
    ntok = 0; mode = 2;
    push(K_GRANT, 15'(4'b0100), 0);
    push(K_ERR, 15'(4'b0100), int'(TIMEOUT));
    req = 4'b0100;
    drain(3000);
    req = '0;
    ntok = 2; mode = 0;
    push_job(4'b0001, 2, 0);
    req = 4'b0001;
    drain(3000);
    req = '0;

    // Reset in the middle of LOAD drops the job; same request re-granted afterwards
    pulse_reset();
    ntok = 1; mode = 0;
    push(K_GRANT, 15'(4'b0001), 0);
    req = 4'b0001;
    k = 0;
    n = 0;
    while (k < 100 && n < 3000) begin
      @(negedge clk);
      if (data_rd) k++;
      n++;
    end
    check("load_reach_100", 32'(k), 32'd100);
    #2 reset = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_data_rd", 32'(data_rd), 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    check("midrst_done_err", 32'({done, err}), 32'd0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    push_job(4'b0001, 1, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    drain(3000);
    req = '0;

    // Last token and finish on the same cycle
    ntok = 2; mode = 1;
    push_job(4'b0010, 2, 1);
    req = 4'b0010;
    drain(3000);
    req = '0;

    repeat (4) @(negedge clk);
    check("final_grant_idle", 32'(grant), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
